// File: rtl/aes_pkg.sv
// aes_pkg: shared AES block/byte types, serializer FSM states and byte-lane helper
package aes_pkg;
    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTES = 16;
    localparam int AES_BYTE_W = 8;
    typedef logic [3:0] byte_idx_t;
    typedef logic [AES_BLOCK_W-1:0] aes_block_t;
    typedef logic [AES_BYTE_W-1:0] aes_byte_t;
    typedef enum logic {IDLE, SEND} ser_state_t;
    // idx counts transmission order; msb_first picks which end of the block goes out first
    function automatic aes_byte_t get_byte(input aes_block_t blk, input byte_idx_t idx, input logic msb_first);
        int lane;
        lane = msb_first ? AES_BYTES - 1 - int'(idx) : int'(idx);
        return blk[lane*AES_BYTE_W +: AES_BYTE_W];
    endfunction
endpackage

// File: rtl/aes_ct_serializer_if.sv
// aes_ct_serializer_if: ciphertext capture inputs plus byte-stream and status outputs
interface aes_ct_serializer_if import aes_pkg::*; #(parameter int CNT_W = 16);
    aes_block_t ciphertext;
    logic done;
    logic ovf_clr;
    logic out_ready;
    aes_byte_t out_data;
    logic out_valid;
    logic out_last;
    logic busy;
    logic overflow;
    logic [CNT_W-1:0] blk_count;
    modport master (
        input ciphertext, done, ovf_clr, out_ready,
        output out_data, out_valid, out_last, busy, overflow, blk_count
    );
    modport slave (
        output ciphertext, done, ovf_clr, out_ready,
        input out_data, out_valid, out_last, busy, overflow, blk_count
    );
endinterface

// File: rtl/aes_block_fifo.sv
// aes_block_fifo: DEPTH x 128-bit block FIFO; push and pop may coincide even when full
module aes_block_fifo import aes_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  aes_block_t wdata,
    output aes_block_t rdata,
    output aes_block_t rdata_nxt,
    output logic [$clog2(DEPTH):0] count,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    aes_block_t mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
    logic [AW:0] count_q, count_d;
    always_comb begin
        rd_ptr_nxt = rd_ptr_q + 1'b1;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_nxt : rd_ptr_q;
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end
    // storage is deliberately unreset; only occupancy decides what is valid
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wdata;
    end
    assign rdata = mem[rd_ptr_q];
    assign rdata_nxt = mem[rd_ptr_nxt];
    assign count = count_q;
    assign full = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;
endmodule

// File: rtl/aes_ct_serializer.sv
// aes_ct_serializer: queues AES ciphertext blocks on done and streams each out as 16 bytes
module aes_ct_serializer import aes_pkg::*; #(
    parameter int DEPTH = 2,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst_n,
    aes_ct_serializer_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    ser_state_t state_q, state_d;
    byte_idx_t byte_cnt_q, byte_cnt_d;
    aes_byte_t out_data_q, out_data_d;
    logic out_valid_q, out_valid_d, out_last_q, out_last_d, overflow_q, overflow_d;
    logic [CNT_W-1:0] blk_count_q, blk_count_d;
    aes_block_t head, head_nxt, next_blk;
    logic [AW:0] count;
    logic full, empty, hs, pop, push, drop, more;
    aes_block_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .wdata(bus.ciphertext),
        .rdata(head), .rdata_nxt(head_nxt), .count(count), .full(full), .empty(empty)
    );
    always_comb begin
        hs = out_valid_q & bus.out_ready;
        pop = hs & out_last_q;
        push = bus.done & (~full | pop);
        drop = bus.done & full & ~pop;
        // after a pop the next head is either already queued or is the block written this cycle
        more = (count > (AW+1)'(1)) | push;
        next_blk = (count > (AW+1)'(1)) ? head_nxt : bus.ciphertext;
        overflow_d = drop | (overflow_q & ~bus.ovf_clr);
        blk_count_d = pop ? blk_count_q + 1'b1 : blk_count_q;
        state_d = state_q;
        byte_cnt_d = byte_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        if (state_q == IDLE) begin
            if (!empty) begin
                state_d = SEND;
                byte_cnt_d = '0;
                out_valid_d = 1'b1;
                out_data_d = get_byte(head, '0, MSB_FIRST);
                out_last_d = 1'b0;
            end
        end else if (hs) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            out_last_d = byte_cnt_d == 4'd15;
            out_valid_d = ~pop | more;
            state_d = out_valid_d ? SEND : IDLE;
            out_data_d = !pop ? get_byte(head, byte_cnt_d, MSB_FIRST) : more ? get_byte(next_blk, '0, MSB_FIRST) : '0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            byte_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            overflow_q <= 1'b0;
            blk_count_q <= '0;
        end else begin
            state_q <= state_d;
            byte_cnt_q <= byte_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            overflow_q <= overflow_d;
            blk_count_q <= blk_count_d;
        end
    end
    assign bus.out_data = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last = out_last_q;
    assign bus.busy = !empty | out_valid_q;
    assign bus.overflow = overflow_q;
    assign bus.blk_count = blk_count_q;
endmodule

// File: tb/tb_aes_ct_serializer.sv
// tb_aes_ct_serializer: scenario tasks plus a block-queue reference model checking every byte handshake
module tb_aes_ct_serializer;
    import aes_pkg::*;
    localparam int DEPTH = 2;
    localparam int CNT_W = 16;
    localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CT2 = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_ct_serializer_if #(.CNT_W(CNT_W)) bus_a ();
    aes_ct_serializer_if #(.CNT_W(CNT_W)) bus_b ();

    aes_ct_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.master)
    );
    aes_ct_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b0), .CNT_W(CNT_W)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.master)
    );

    assign bus_b.ciphertext = bus_a.ciphertext;
    assign bus_b.done = bus_a.done;
    assign bus_b.ovf_clr = bus_a.ovf_clr;
    assign bus_b.out_ready = bus_a.out_ready;

    int errors = 0;
    int checks = 0;

    // reference model: queue of accepted blocks, position inside head block, sticky flag, count
    logic [127:0] mq[$];
    int midx = 0;
    logic movf = 1'b0;
    logic [CNT_W-1:0] mblk = '0;
    int hs_cnt = 0;
    logic held = 1'b0;
    logic [7:0] held_data;
    logic held_last;
    logic [7:0] a_bytes[$];
    logic [7:0] b_bytes[$];

    function automatic logic [7:0] exp_byte(input logic [127:0] blk, input int idx, input bit msb);
        int sh;
        logic [127:0] t;
        sh = msb ? (15 - idx) * 8 : idx * 8;
        t = blk >> sh;
        return t[7:0];
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            midx = 0;
            movf = 1'b0;
            mblk = '0;
            held = 1'b0;
        end else begin
            checks++;
            if (bus_a.overflow !== movf) begin
                errors++;
                $display("FAIL overflow: got %b expected %b", bus_a.overflow, movf);
            end
            checks++;
            if (bus_a.blk_count !== mblk) begin
                errors++;
                $display("FAIL blk_count: got %0d expected %0d", bus_a.blk_count, mblk);
            end
            checks++;
            if (bus_a.busy !== (mq.size() != 0)) begin
                errors++;
                $display("FAIL busy: got %b expected %b", bus_a.busy, mq.size() != 0);
            end
            if (held) begin
                checks++;
                if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== held_data || bus_a.out_last !== held_last) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                             bus_a.out_valid, bus_a.out_data, bus_a.out_last, held_data, held_last);
                end
            end
            held = bus_a.out_valid & ~bus_a.out_ready;
            held_data = bus_a.out_data;
            held_last = bus_a.out_last;
            if (bus_a.out_valid && bus_a.out_ready) begin
                hs_cnt++;
                a_bytes.push_back(bus_a.out_data);
                b_bytes.push_back(bus_b.out_data);
                checks++;
                if (mq.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_byte: got handshake d=%h expected no data queued", bus_a.out_data);
                end else begin
                    if (bus_a.out_data !== exp_byte(mq[0], midx, 1'b1)) begin
                        errors++;
                        $display("FAIL byte_msb[%0d]: got %h expected %h", midx, bus_a.out_data, exp_byte(mq[0], midx, 1'b1));
                    end
                    checks++;
                    if (bus_a.out_last !== (midx == 15)) begin
                        errors++;
                        $display("FAIL last[%0d]: got %b expected %b", midx, bus_a.out_last, midx == 15);
                    end
                    checks++;
                    if (bus_b.out_data !== exp_byte(mq[0], midx, 1'b0)) begin
                        errors++;
                        $display("FAIL byte_lsb[%0d]: got %h expected %h", midx, bus_b.out_data, exp_byte(mq[0], midx, 1'b0));
                    end
                    midx++;
                    if (midx == 16) begin
                        void'(mq.pop_front());
                        midx = 0;
                        mblk++;
                    end
                end
            end
            if (bus_a.done) begin
                if (mq.size() < DEPTH) mq.push_back(bus_a.ciphertext);
                else movf = 1'b1;
            end else if (bus_a.ovf_clr) begin
                movf = 1'b0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_done(input logic [127:0] ct);
        bus_a.ciphertext = ct;
        bus_a.done = 1'b1;
        cyc(1);
        bus_a.done = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        bus_a.out_ready = 1'b1;
        while ((bus_a.busy || mq.size() != 0) && n < limit) begin
            cyc(1);
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL drain_timeout: got busy=%b queued=%0d expected idle within %0d cycles", bus_a.busy, mq.size(), limit);
        end
    endtask

    task automatic wait_midx(input int target);
        int n;
        n = 0;
        while (midx != target && n < 100) begin
            cyc(1);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL wait_byte: got index %0d expected %0d", midx, target);
        end
    endtask

    task automatic test_reset();
        bus_a.ciphertext = '0;
        bus_a.done = 1'b0;
        bus_a.ovf_clr = 1'b0;
        bus_a.out_ready = 1'b0;
        cyc(3);
        checks++;
        if ({bus_a.out_valid, bus_a.out_last, bus_a.busy, bus_a.overflow} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got v=%b l=%b busy=%b ovf=%b expected all 0",
                     bus_a.out_valid, bus_a.out_last, bus_a.busy, bus_a.overflow);
        end
        checks++;
        if (bus_a.out_data !== 8'h00 || bus_a.blk_count !== '0) begin
            errors++;
            $display("FAIL reset_data: got d=%h cnt=%0d expected 00 and 0", bus_a.out_data, bus_a.blk_count);
        end
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_single();
        int h0;
        a_bytes.delete();
        bus_a.out_ready = 1'b1;
        bus_a.ciphertext = CT1;
        bus_a.done = 1'b1;
        cyc(1);
        bus_a.done = 1'b0;
        checks++;
        if (bus_a.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got out_valid=%b expected 0", bus_a.out_valid);
        end
        cyc(1);
        h0 = hs_cnt;
        checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 8'h39) begin
            errors++;
            $display("FAIL latency_first: got v=%b d=%h expected v=1 d=39", bus_a.out_valid, bus_a.out_data);
        end
        drain(100);
        checks++;
        if (hs_cnt - h0 != 16 || a_bytes.size() != 16) begin
            errors++;
            $display("FAIL single_count: got %0d bytes expected 16", hs_cnt - h0);
        end else begin
            checks++;
            if (a_bytes[15] !== 8'h32 || a_bytes[1] !== 8'h25) begin
                errors++;
                $display("FAIL single_bytes: got b1=%h b15=%h expected 25 and 32", a_bytes[1], a_bytes[15]);
            end
        end
        checks++;
        if (bus_a.blk_count !== 16'd1 || bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got cnt=%0d busy=%b expected 1 and 0", bus_a.blk_count, bus_a.busy);
        end
    endtask

    task automatic test_backpressure();
        int h0;
        int k;
        logic [CNT_W-1:0] c0;
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        h0 = hs_cnt;
        c0 = bus_a.blk_count;
        bus_a.out_ready = 1'b1;
        pulse_done(CT1);
        k = 1;
        while (bus_a.blk_count == c0 && k < 200) begin
            bus_a.out_ready = pat[k % 4];
            cyc(1);
            k++;
        end
        bus_a.out_ready = 1'b1;
        checks++;
        if (hs_cnt - h0 != 16) begin
            errors++;
            $display("FAIL bp_handshakes: got %0d expected 16", hs_cnt - h0);
        end
        checks++;
        if (bus_a.overflow !== 1'b0 || bus_a.blk_count !== c0 + 1'b1) begin
            errors++;
            $display("FAIL bp_status: got ovf=%b cnt=%0d expected 0 and %0d", bus_a.overflow, bus_a.blk_count, c0 + 1'b1);
        end
        drain(50);
    endtask

    task automatic test_back_to_back();
        int bubbles;
        int n;
        logic [CNT_W-1:0] c0;
        c0 = bus_a.blk_count;
        a_bytes.delete();
        bus_a.out_ready = 1'b1;
        pulse_done(CT1);
        wait_midx(5);
        pulse_done(CT2);
        bubbles = 0;
        n = 0;
        while (bus_a.blk_count != c0 + 2'd2 && n < 80) begin
            if (!bus_a.out_valid) bubbles++;
            cyc(1);
            n++;
        end
        checks++;
        if (bubbles != 0 || bus_a.blk_count !== c0 + 2'd2) begin
            errors++;
            $display("FAIL b2b: got bubbles=%0d cnt=%0d expected 0 and %0d", bubbles, bus_a.blk_count, c0 + 2'd2);
        end
        checks++;
        if (a_bytes.size() != 32 || a_bytes[15] !== 8'h32 || a_bytes[16] !== 8'h00) begin
            errors++;
            $display("FAIL b2b_seam: got %0d bytes expected 32 with 32 then 00 at the seam", a_bytes.size());
        end
        drain(50);
    endtask

    task automatic test_overflow();
        int h0;
        logic [CNT_W-1:0] c0;
        c0 = bus_a.blk_count;
        h0 = hs_cnt;
        bus_a.out_ready = 1'b0;
        pulse_done(CT1);
        pulse_done(CT2);
        pulse_done({$urandom, $urandom, $urandom, $urandom});
        cyc(1);
        checks++;
        if (bus_a.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got %b expected 1", bus_a.overflow);
        end
        drain(100);
        checks++;
        if (bus_a.blk_count !== c0 + 2'd2 || hs_cnt - h0 != 32) begin
            errors++;
            $display("FAIL ovf_drain: got cnt=%0d bytes=%0d expected %0d and 32", bus_a.blk_count, hs_cnt - h0, c0 + 2'd2);
        end
        checks++;
        if (bus_a.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b expected 1", bus_a.overflow);
        end
        bus_a.ovf_clr = 1'b1;
        cyc(1);
        bus_a.ovf_clr = 1'b0;
        checks++;
        if (bus_a.overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 0", bus_a.overflow);
        end
    endtask

    task automatic test_full_coincide();
        int n;
        logic [CNT_W-1:0] c0;
        c0 = bus_a.blk_count;
        bus_a.out_ready = 1'b0;
        pulse_done(CT1);
        pulse_done(CT2);
        cyc(2);
        bus_a.out_ready = 1'b1;
        n = 0;
        while (!(bus_a.out_valid && bus_a.out_last) && n < 60) begin
            cyc(1);
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL coincide_wait: got no last byte expected one within 60 cycles");
        end
        pulse_done({$urandom, $urandom, $urandom, $urandom});
        drain(100);
        checks++;
        if (bus_a.overflow !== 1'b0 || bus_a.blk_count !== c0 + 2'd3) begin
            errors++;
            $display("FAIL coincide: got ovf=%b cnt=%0d expected 0 and %0d", bus_a.overflow, bus_a.blk_count, c0 + 2'd3);
        end
    endtask

    task automatic test_reset_mid();
        bus_a.out_ready = 1'b1;
        pulse_done(CT1);
        wait_midx(7);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_a.out_valid, bus_a.out_last, bus_a.busy} !== 3'b0 || bus_a.out_data !== 8'h00 || bus_a.blk_count !== '0) begin
            errors++;
            $display("FAIL async_reset: got v=%b l=%b busy=%b d=%h cnt=%0d expected all 0",
                     bus_a.out_valid, bus_a.out_last, bus_a.busy, bus_a.out_data, bus_a.blk_count);
        end
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        a_bytes.delete();
        pulse_done(CT2);
        drain(100);
        checks++;
        if (a_bytes.size() != 16 || a_bytes[0] !== 8'h00 || a_bytes[15] !== 8'hff || bus_a.blk_count !== 16'd1) begin
            errors++;
            $display("FAIL reset_restart: got %0d bytes cnt=%0d expected 16 bytes 00..ff and cnt 1", a_bytes.size(), bus_a.blk_count);
        end
    endtask

    task automatic test_msb_first();
        b_bytes.delete();
        bus_a.out_ready = 1'b1;
        pulse_done(CT1);
        drain(100);
        checks++;
        if (b_bytes.size() != 16 || b_bytes[0] !== 8'h32 || b_bytes[1] !== 8'h0b || b_bytes[2] !== 8'h6a || b_bytes[15] !== 8'h39) begin
            errors++;
            $display("FAIL lsb_order: got %0d bytes expected 32,0b,6a,...,39", b_bytes.size());
        end
    endtask

    task automatic test_random();
        bus_a.ovf_clr = 1'b0;
        for (int i = 0; i < 600; i++) begin
            bus_a.out_ready = ($urandom_range(0, 9) < 7);
            bus_a.done = ($urandom_range(0, 11) == 0);
            bus_a.ciphertext = {$urandom, $urandom, $urandom, $urandom};
            bus_a.ovf_clr = ($urandom_range(0, 49) == 0);
            cyc(1);
        end
        bus_a.done = 1'b0;
        bus_a.ovf_clr = 1'b0;
        drain(200);
        checks++;
        if (bus_a.blk_count !== mblk || bus_a.overflow !== movf) begin
            errors++;
            $display("FAIL random_end: got cnt=%0d ovf=%b expected %0d and %b", bus_a.blk_count, bus_a.overflow, mblk, movf);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_full_coincide();
        test_msb_first();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected completion within 2 ms");
        $fatal(1);
    end
endmodule
